// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: ALU operation codes, opcode/funct values,
// the decoded-operation record and instruction field helpers.
package dlx_pkg;

    typedef enum logic [3:0] {
        ALU_NOP   = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_ZSEL  = 4'd8,
        ALU_NZSEL = 4'd9,
        ALU_SEQ   = 4'd10,
        ALU_SLE   = 4'd11,
        ALU_SLT   = 4'd12,
        ALU_SNE   = 4'd13
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SLEI  = 6'h1C;

    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SEQ = 6'h28;
    localparam logic [5:0] FN_SNE = 6'h29;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLE = 6'h2C;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wb;
        logic        branch;
        logic        illegal;
    } dec_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] i);
        return i[31:26];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] i);
        return i[25:21];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] i);
        return i[20:16];
    endfunction

    function automatic logic [4:0] f_rd_r(input logic [31:0] i);
        return i[15:11];
    endfunction

    function automatic logic [4:0] f_rd_i(input logic [31:0] i);
        return i[20:16];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] i);
        return i[5:0];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] i);
        return i[15:0];
    endfunction

endpackage

// File: rtl/dlx_regfile.sv
// 32x32 integer register file: two read ports, one write port with
// write-through bypass; r0 always reads zero and ignores writes.
module dlx_regfile
    import dlx_pkg::*;
#(
    parameter bit RESET_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];
    logic        w_wr;

    assign w_wr = i_we && (i_wa != 5'd0);

    generate
        if (RESET_ZERO) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) r_mem[i] <= '0;
                end else if (w_wr) begin
                    r_mem[i_wa] <= i_wd;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (w_wr) r_mem[i_wa] <= i_wd;
            end
        end
    endgenerate

    // a same-cycle write must be seen by the decode reading that register
    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 :
                   (w_wr && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 :
                   (w_wr && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/dlx_decode.sv
// DLX decode stage: combinational instruction decode feeding one registered
// valid/ready output stage toward execute; owns the register-file write port.
module dlx_decode
    import dlx_pkg::*;
#(
    parameter bit RESET_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic        out_wb,
    output logic        out_branch,
    output logic        out_illegal
);

    logic [31:0] w_rs1_data, w_rs2_data;
    logic [31:0] w_imm_s, w_imm_z;
    logic [5:0]  w_opcode;
    alu_op_e     w_op;
    logic        w_legal, w_is_r, w_is_br, w_zext;
    dec_t        w_dec;
    logic        w_accept;
    dec_t        r_out;
    logic        r_valid;

    dlx_regfile #(.RESET_ZERO(RESET_ZERO)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (f_rs1(in_instr)),
        .i_ra2 (f_rs2(in_instr)),
        .o_rd1 (w_rs1_data),
        .o_rd2 (w_rs2_data),
        .i_we  (wb_en),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    assign w_opcode = f_opcode(in_instr);
    assign w_imm_s  = {{16{in_instr[15]}}, f_imm(in_instr)};
    assign w_imm_z  = {16'd0, f_imm(in_instr)};
    assign w_is_r   = (w_opcode == OP_RTYPE);
    assign w_is_br  = (w_opcode == OP_BEQZ) || (w_opcode == OP_BNEZ);

    always_comb begin
        w_op    = ALU_NOP;
        w_legal = 1'b1;
        w_zext  = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case (f_funct(in_instr))
                    FN_ADD:  w_op = ALU_ADD;
                    FN_SUB:  w_op = ALU_SUB;
                    FN_AND:  w_op = ALU_AND;
                    FN_OR:   w_op = ALU_OR;
                    FN_XOR:  w_op = ALU_XOR;
                    FN_SLL:  w_op = ALU_SLL;
                    FN_SRL:  w_op = ALU_SRL;
                    FN_SEQ:  w_op = ALU_SEQ;
                    FN_SNE:  w_op = ALU_SNE;
                    FN_SLT:  w_op = ALU_SLT;
                    FN_SLE:  w_op = ALU_SLE;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI: w_op = ALU_ADD;
            OP_SUBI: w_op = ALU_SUB;
            OP_ANDI: begin w_op = ALU_AND; w_zext = 1'b1; end
            OP_ORI:  begin w_op = ALU_OR;  w_zext = 1'b1; end
            OP_XORI: begin w_op = ALU_XOR; w_zext = 1'b1; end
            OP_SLLI: w_op = ALU_SLL;
            OP_SRLI: w_op = ALU_SRL;
            OP_SEQI: w_op = ALU_SEQ;
            OP_SNEI: w_op = ALU_SNE;
            OP_SLTI: w_op = ALU_SLT;
            OP_SLEI: w_op = ALU_SLE;
            OP_BEQZ: w_op = ALU_ZSEL;
            OP_BNEZ: w_op = ALU_NZSEL;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_dec = '0;
        if (w_legal) begin
            w_dec.alu_op = w_op;
            w_dec.op1    = w_rs1_data;
            if (w_is_r) begin
                w_dec.op2 = w_rs2_data;
                w_dec.rd  = f_rd_r(in_instr);
            end else if (w_is_br) begin
                // branch target computed here; ALU passes it through when taken
                w_dec.op2    = in_pc + 32'd4 + w_imm_s;
                w_dec.branch = 1'b1;
            end else begin
                w_dec.op2 = w_zext ? w_imm_z : w_imm_s;
                w_dec.rd  = f_rd_i(in_instr);
            end
            w_dec.wb = !w_is_br && (w_dec.rd != 5'd0);
        end else begin
            w_dec.illegal = 1'b1;
        end
    end

    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_alu_op  = r_out.alu_op;
    assign out_op1     = r_out.op1;
    assign out_op2     = r_out.op2;
    assign out_rd      = r_out.rd;
    assign out_wb      = r_out.wb;
    assign out_branch  = r_out.branch;
    assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_dlx_decode.sv
// Directed self-checking bench for dlx_decode: decode table, handshake
// back-pressure, writeback bypass, flush and asynchronous reset.
module tb_dlx_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_alu_op;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_wb, out_branch, out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlx_decode #(.RESET_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_wb      (out_wb),
        .out_branch  (out_branch),
        .out_illegal (out_illegal)
    );

    // {valid, alu_op, op1, op2, rd, wb, branch, illegal}
    function automatic logic [76:0] mk(input logic v, input logic [3:0] op,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rd, input logic wb,
                                       input logic br, input logic ill);
        return {v, op, a, b, rd, wb, br, ill};
    endfunction

    function automatic logic [76:0] obs();
        return {out_valid, out_alu_op, out_op1, out_op2, out_rd, out_wb, out_branch, out_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [76:0] e;
        tick();
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs(), 77'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        // registers cleared: ADD r3,r1,r2 reads zeros
        issue(32'h00221820, 32'h0);
        e = mk(1, 4'd1, 32'd0, 32'd0, 5'd3, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL reset_regfile got %h exp %h", obs(), e);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ti [16];
        logic [31:0] tp [16];
        logic [76:0] te [16];
        ti[0]  = 32'h00221820; tp[0]  = 0;     te[0]  = mk(1, 4'd1,  5, 3,            5'd3, 1, 0, 0);
        ti[1]  = 32'h00222822; tp[1]  = 0;     te[1]  = mk(1, 4'd2,  5, 3,            5'd5, 1, 0, 0);
        ti[2]  = 32'h0041302A; tp[2]  = 0;     te[2]  = mk(1, 4'd12, 3, 5,            5'd6, 1, 0, 0);
        ti[3]  = 32'h00220020; tp[3]  = 0;     te[3]  = mk(1, 4'd1,  5, 3,            5'd0, 0, 0, 0);
        ti[4]  = 32'h3024FFFF; tp[4]  = 0;     te[4]  = mk(1, 4'd3,  5, 32'h0000FFFF, 5'd4, 1, 0, 0);
        ti[5]  = 32'h2024FFFF; tp[5]  = 0;     te[5]  = mk(1, 4'd1,  5, 32'hFFFFFFFF, 5'd4, 1, 0, 0);
        ti[6]  = 32'h58288000; tp[6]  = 0;     te[6]  = mk(1, 4'd7,  5, 32'hFFFF8000, 5'd8, 1, 0, 0);
        ti[7]  = 32'h38298000; tp[7]  = 0;     te[7]  = mk(1, 4'd5,  5, 32'h00008000, 5'd9, 1, 0, 0);
        ti[8]  = 32'h1020FFF8; tp[8]  = 32'h100; te[8] = mk(1, 4'd8, 5, 32'h000000FC, 5'd0, 0, 1, 0);
        ti[9]  = 32'h1420FFF8; tp[9]  = 32'h200; te[9] = mk(1, 4'd9, 5, 32'h000001FC, 5'd0, 0, 1, 0);
        ti[10] = 32'hFC221820; tp[10] = 0;     te[10] = mk(1, 4'd0,  0, 0,            5'd0, 0, 0, 1);
        ti[11] = 32'h00221801; tp[11] = 0;     te[11] = mk(1, 4'd0,  0, 0,            5'd0, 0, 0, 1);
        ti[12] = 32'h0022182C; tp[12] = 0;     te[12] = mk(1, 4'd11, 5, 3,            5'd3, 1, 0, 0);
        ti[13] = 32'h60230005; tp[13] = 0;     te[13] = mk(1, 4'd10, 5, 5,            5'd3, 1, 0, 0);
        ti[14] = 32'h00221829; tp[14] = 0;     te[14] = mk(1, 4'd13, 5, 3,            5'd3, 1, 0, 0);
        ti[15] = 32'h50220002; tp[15] = 0;     te[15] = mk(1, 4'd6,  5, 2,            5'd2, 1, 0, 0);
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_instr = ti[k]; in_pc = tp[k];
            tick();
            checks++;
            if (obs() !== te[k]) begin
                errors++; $display("FAIL decode_%0d instr %h got %h exp %h", k, ti[k], obs(), te[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL decode_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [76:0] ea, eb;
        ea = mk(1, 4'd1, 5, 3, 5'd3, 1, 0, 0);
        eb = mk(1, 4'd2, 5, 3, 5'd5, 1, 0, 0);
        out_ready = 1'b0;
        issue(32'h00221820, 32'h0);
        in_valid = 1'b1; in_instr = 32'h00222822;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_in_ready_%0d got %b exp 0", k, in_ready);
            end
            tick();
            checks++;
            if (obs() !== ea) begin
                errors++; $display("FAIL hold_stable_%0d got %h exp %h", k, obs(), ea);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== eb) begin
            errors++; $display("FAIL release_next got %h exp %h", obs(), eb);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [76:0] e;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000DEAD;
        issue(32'h00E05020, 32'h0);
        wb_en = 1'b0;
        e = mk(1, 4'd1, 32'h0000DEAD, 0, 5'd10, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL bypass_r7 got %h exp %h", obs(), e);
        end
        issue(32'h00E05020, 32'h0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL stored_r7 got %h exp %h", obs(), e);
        end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h00001234;
        issue(32'h00005820, 32'h0);
        wb_en = 1'b0;
        e = mk(1, 4'd1, 0, 0, 5'd11, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL r0_bypass got %h exp %h", obs(), e);
        end
        issue(32'h00005820, 32'h0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL r0_stored got %h exp %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(32'h00221820, 32'h0);
        in_valid = 1'b1; in_instr = 32'h00222822; out_ready = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_not_taken got %b exp 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [76:0] e;
        out_ready = 1'b0;
        issue(32'h00221820, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL async_reset got %h exp %h", obs(), 77'd0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_ready got %b exp 1", in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(32'h00221820, 32'h0);
        e = mk(1, 4'd1, 0, 0, 5'd3, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL async_reset_regfile got %h exp %h", obs(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode();
        test_back_pressure();
        test_bypass();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_decode.md
# dlx_decode

Decode stage of the DLX pipeline and the producer side of the ALU interface. Accepts one 32-bit DLX instruction per cycle over a valid/ready handshake, reads source operands from the integer register file, and registers the 4-bit ALU operation code plus both 32-bit operands for the execute stage. Also owns the register-file write port driven by writeback.

## Interface
Parameters:
- RESET_ZERO, 1, when 1 the register file clears to zero on reset; when 0 it is not reset
Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_instr/in_pc valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  DLX instruction word
- in_pc  in  32  address of in_instr
- flush  in  1  discard held output, refuse input this cycle
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  32  write data
- out_valid  out  1  decoded operation held
- out_ready  in  1  execute consumes this cycle
- out_alu_op  out  4  ALU operation code
- out_op1  out  32  ALU first operand
- out_op2  out  32  ALU second operand
- out_rd  out  5  destination register (0 when none)
- out_wb  out  1  result is written back
- out_branch  out  1  conditional branch; ALU result nonzero = taken target
- out_illegal  out  1  undecodable instruction

## Operation
- ALU codes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 ZSEL (op1==0 ? op2 : 0), 9 NZSEL (op1!=0 ? op2 : 0), 10 SEQ, 11 SLE, 12 SLT, 13 SNE.
- Fields: opcode[31:26], rs1[25:21]; R-type rs2[20:16], rd[15:11], funct[5:0]; I-type rd[20:16], imm[15:0].
- R-type (opcode 0x00), funct -> code: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x04 SLL, 0x06 SRL, 0x28 SEQ, 0x29 SNE, 0x2A SLT, 0x2C SLE. op1=R[rs1], op2=R[rs2], out_wb=1.
- I-type opcode -> code: 0x08 ADD, 0x0A SUB, 0x0C AND, 0x0D OR, 0x0E XOR, 0x14 SLL, 0x16 SRL, 0x18 SEQ, 0x19 SNE, 0x1A SLT, 0x1C SLE. op1=R[rs1], out_wb=1. op2 = zero-extended imm for AND/OR/XOR, sign-extended otherwise.
- BEQZ 0x04 -> ZSEL, BNEZ 0x05 -> NZSEL: op1=R[rs1], op2=in_pc+4+sext(imm) (mod 2^32), out_branch=1, out_wb=0, out_rd=0.
- Any other opcode/funct: out_illegal=1, code 0, op1=op2=0, out_wb=0, out_rd=0.
- out_wb forced 0 when rd==0 (r0 writes are no-ops).
- Register file: 32x32, R[0] reads 0 always; wb_en with wb_addr 0 ignored. Read of the index being written in the same cycle returns wb_data (write-through bypass).
- No hazard detection or forwarding beyond the bypass; interlock belongs to the pipeline controller.

## Timing
- Reset: out_valid=0, out_alu_op=0, out_op1=out_op2=0, out_rd=0, out_wb=out_branch=out_illegal=0; in_ready=1 after reset deasserts.
- in_ready = !flush && (!out_valid || out_ready). Accept when in_valid && in_ready; outputs update next edge, latency 1, throughput 1/cycle.
- Held outputs stable while out_valid && !out_ready.
- flush: next edge out_valid=0, no acceptance; flush wins over simultaneous in_valid and out_ready.
- Writeback is independent of handshake; a write in the acceptance cycle is visible to that decode.
- Async reset mid-stream drops the held operation immediately.

## Structure
- dlx_pkg: alu_op_e enum (codes above), opcode/funct localparams, field slice helpers.
- Sub-module dlx_regfile: 2 read ports, 1 write port, bypass, r0 zero, RESET_ZERO.
- dlx_decode: combinational decoder + one output register stage.

## Test plan
- Reset then write R1=5, R2=3; decode ADD r3,r1,r2 (0x00221820) -> out_alu_op=1, op1=5, op2=3, out_rd=3, out_wb=1 one cycle after acceptance.
- ANDI r4,r1,0xFFFF -> op2=0x0000FFFF; ADDI r4,r1,0xFFFF -> op2=0xFFFFFFFF.
- BEQZ r1,-8 at pc=0x100 -> code 8, op1=R1, op2=0x000000FC, out_branch=1, out_wb=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next instruction accepted same cycle.
- wb_en to r7=0xDEAD in same cycle as decode reading r7 -> op1=0xDEAD; write to r0 -> reads stay 0.
- opcode 0x3F -> out_illegal=1, code 0; flush with out_valid=1 -> out_valid=0 next cycle, input not taken.
